cyp_sdram_wr_burst: RTL and testbench
=====================================

// Module: cyp_sdram_wr_burst
// PURPOSE
//  Downstream stage of the Cypress EP2-OUT write FIFO. Sits in the sdram_clk domain.
//  Drains 16-bit words from the async FIFO read port into a local burst buffer.
//  Issues one SDRAM write request per burst and streams the buffer to the controller.
//  The SDRAM write address advances linearly and wraps at ADDR_LIMIT.
// PARAMETERS
//  BURST_LEN    256      words per full burst (1..256)
//  ADDR_W       24       SDRAM word-address width
//  ADDR_LIMIT   2**24    address wrap point in words; must be a multiple of BURST_LEN
//  FLUSH_TO     1024     consecutive FIFO-empty cycles before a partial burst is flushed
// PORTS
//  sdram_clk        in   1       single clock (133 MHz)
//  rst_n            in   1       synchronous, active-low reset
//  sdram_init_done  in   1       SDRAM init complete; block is idle while low
//  fifo_rempty      in   1       write-FIFO empty flag
//  fifo_ren         out  1       write-FIFO read enable; standard FIFO, dout valid 1 cycle after ren
//  fifo_rdata       in   16      write-FIFO read data
//  sdram_wr_req     out  1       burst write request; held until ack
//  sdram_wr_ack     in   1       controller accepted the request (1-cycle pulse)
//  sdram_wr_addr    out  ADDR_W  burst start word address; stable while req is high
//  sdram_wr_len     out  9       burst length in words (1..BURST_LEN); stable while req is high
//  sdram_wr_data_req in  1       controller pulls one word per cycle while high
//  sdram_wr_data    out  16      word for the current data_req; 0 outside XFER
//  wr_busy          out  1       high in any state other than IDLE
//  wr_words_total   out  32      count of words delivered to SDRAM; wraps at 2^32
// BEHAVIOUR
//  Reset: state=IDLE; fifo_ren=0, sdram_wr_req=0, addr=0, len=0, wr_words_total=0, wr_busy=0.
//  Reset applies in any state and aborts the burst in progress; buffered words are discarded.
//  States:
//   IDLE  -> FILL when sdram_init_done=1. init_done is sampled only in IDLE.
//   FILL  fifo_ren = !fifo_rempty && (issued < BURST_LEN).
//         The word is written to buf[fill_cnt] on the cycle after a ren (ren_d).
//         fill_cnt increments per captured word.
//         -> REQ when fill_cnt == BURST_LEN.
//         -> REQ with partial length when empty_cnt reaches FLUSH_TO, fill_cnt > 0, and no read is outstanding.
//         empty_cnt clears whenever fifo_rempty=0 or a word is captured; it saturates at FLUSH_TO.
//   REQ   sdram_wr_req=1, sdram_wr_len=fill_cnt, sdram_wr_addr=cur_addr; no FIFO reads.
//         -> XFER on the cycle sdram_wr_ack=1; req drops the following cycle.
//   XFER  sdram_wr_data = buf[rd_idx] combinationally.
//         rd_idx and wr_words_total increment on each data_req=1.
//         After len words: cur_addr += len, set to 0 if the result >= ADDR_LIMIT; fill_cnt, rd_idx, empty_cnt clear.
//         -> FILL (-> IDLE instead if init_done=0).
//         data_req after the last word is ignored (data=0, no count).
//  FIFO rule: never assert fifo_ren while fifo_rempty=1 or outside FILL.
//  Total outstanding+captured words never exceed BURST_LEN.
//  Simultaneous ack and data_req in the same cycle: only the ack takes effect; data starts next cycle.
//  Latency: first FIFO word to sdram_wr_req on a full burst = BURST_LEN+1 cycles if the FIFO never empties.
// TESTING
//  1 Reset, init_done=0, FIFO non-empty for 100 cycles -> fifo_ren stays 0, wr_busy=0.
//  2 512 words 0..511 in FIFO, ack 3 cycles after req, data_req continuous ->
//    two bursts: addr 0, len 256, data 0..255; then addr 256, data 256..511; wr_words_total=512.
//  3 10 words then FIFO empty -> after FLUSH_TO cycles, req with len=10, addr=0; next burst addr=10.
//  4 ADDR_LIMIT=512: three full bursts -> third burst addr=0.
//  5 Gapped data_req (1 of 3 cycles) -> words in order, none skipped or duplicated.
//  6 rst_n low mid-XFER -> req=0, ren=0, addr=0 next cycle; restart writes from addr 0.

Source files
------------

// File: rtl/cyp_sdram_wr_burst_if.sv
// ---------------------------------------------------------------------------
// CypSdramWrBurstIf
// Purpose : groups the write-FIFO read port and the SDRAM write-request /
//           data-pull signals of the EP2-OUT burst writer into one bundle.
// Ports   : fifo_rempty, fifo_ren, fifo_rdata         write-FIFO read side
//           sdram_wr_req/ack/addr/len                 burst request handshake
//           sdram_wr_data_req, sdram_wr_data          per-word data pull
//           wr_busy, wr_words_total                   status
// Modports: master = burst writer, slave = FIFO + SDRAM controller side.
// ---------------------------------------------------------------------------
interface cyp_sdram_wr_burst_if #(
   parameter int ADDR_W = 24
);
   logic              fifo_rempty;
   logic              fifo_ren;
   logic [15:0]       fifo_rdata;
   logic              sdram_wr_req;
   logic              sdram_wr_ack;
   logic [ADDR_W-1:0] sdram_wr_addr;
   logic [8:0]        sdram_wr_len;
   logic              sdram_wr_data_req;
   logic [15:0]       sdram_wr_data;
   logic              wr_busy;
   logic [31:0]       wr_words_total;

   modport master (
      input  fifo_rempty, fifo_rdata, sdram_wr_ack, sdram_wr_data_req,
      output fifo_ren, sdram_wr_req, sdram_wr_addr, sdram_wr_len,
             sdram_wr_data, wr_busy, wr_words_total
   );

   modport slave (
      output fifo_rempty, fifo_rdata, sdram_wr_ack, sdram_wr_data_req,
      input  fifo_ren, sdram_wr_req, sdram_wr_addr, sdram_wr_len,
             sdram_wr_data, wr_busy, wr_words_total
   );
endinterface

// File: rtl/cyp_sdram_wr_burst.sv
// ---------------------------------------------------------------------------
// cyp_sdram_wr_burst
// Purpose : sdram_clk-domain drain of the Cypress EP2-OUT write FIFO. Words are
//           collected into a local burst buffer, then one SDRAM write request
//           is issued per burst and the buffer is streamed to the controller.
//           The write address advances linearly and wraps to 0 at ADDR_LIMIT.
//           A partial burst is flushed after FLUSH_TO consecutive empty cycles.
// Ports   : sdram_clk        single clock
//           rst_n            synchronous active-low reset
//           sdram_init_done  SDRAM ready; only looked at while idle
//           bus (master)     FIFO read port, request handshake, data pull,
//                            wr_busy and wr_words_total status
// ---------------------------------------------------------------------------
module cyp_sdram_wr_burst #(
   parameter int BURST_LEN  = 256,
   parameter int ADDR_W     = 24,
   parameter int ADDR_LIMIT = 2**24,
   parameter int FLUSH_TO   = 1024
) (
   input  logic                 sdram_clk,
   input  logic                 rst_n,
   input  logic                 sdram_init_done,
   cyp_sdram_wr_burst_if.master bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_REQ  = 2'd2;
   localparam logic [1:0] S_XFER = 2'd3;

   localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int EC_W  = $clog2(FLUSH_TO + 1);

   localparam logic [8:0]      FULL_CNT  = 9'(BURST_LEN);
   localparam logic [9:0]      FULL_CNT10 = 10'(BURST_LEN);
   localparam logic [EC_W-1:0] EMPTY_MAX = EC_W'(FLUSH_TO);
   localparam logic [ADDR_W:0] LIMIT     = (ADDR_W+1)'(ADDR_LIMIT);

   logic [1:0]        r_state;
   logic [15:0]       r_buf [0:BURST_LEN-1];
   logic [8:0]        r_fill_cnt;
   logic [8:0]        r_rd_idx;
   logic [EC_W-1:0]   r_empty_cnt;
   logic              r_ren_d;
   logic [ADDR_W-1:0] r_cur_addr;
   logic              r_req;
   logic [8:0]        r_len;
   logic [31:0]       r_total;

   logic              w_ren;
   logic              w_flush;
   logic [9:0]        w_issued;
   logic [ADDR_W:0]   w_sum;
   logic [ADDR_W-1:0] w_next_addr;
   logic [IDX_W-1:0]  w_fill_ptr;
   logic [IDX_W-1:0]  w_rd_ptr;

   // A read in flight (r_ren_d) already owns a buffer slot, so it counts
   // against the burst size together with the captured words.
   assign w_issued = 10'(r_fill_cnt) + 10'(r_ren_d);
   assign w_ren    = (r_state == S_FILL) && !bus.fifo_rempty && (w_issued < FULL_CNT10);

   // Flushing also requires the FIFO to still be empty right now, so a word
   // that shows up on the flush cycle is never read and then dropped.
   assign w_flush = (r_empty_cnt == EMPTY_MAX) && (r_fill_cnt != 9'd0) &&
                    !r_ren_d && bus.fifo_rempty;

   assign w_sum       = {1'b0, r_cur_addr} + (ADDR_W+1)'(r_len);
   assign w_next_addr = (w_sum >= LIMIT) ? '0 : w_sum[ADDR_W-1:0];

   assign w_fill_ptr = r_fill_cnt[IDX_W-1:0];
   assign w_rd_ptr   = r_rd_idx[IDX_W-1:0];

   assign bus.fifo_ren       = w_ren;
   assign bus.sdram_wr_req   = r_req;
   assign bus.sdram_wr_addr  = r_cur_addr;
   assign bus.sdram_wr_len   = r_len;
   assign bus.sdram_wr_data  = ((r_state == S_XFER) && (r_rd_idx < r_len)) ? r_buf[w_rd_ptr] : 16'd0;
   assign bus.wr_busy        = (r_state != S_IDLE);
   assign bus.wr_words_total = r_total;

   // Burst buffer: the FIFO presents its word one cycle after the read
   // enable, so the capture is keyed on the delayed enable. Contents need no
   // reset because fill_cnt decides what is valid.
   always_ff @(posedge sdram_clk) begin
      if (r_ren_d) begin
         r_buf[w_fill_ptr] <= bus.fifo_rdata;
      end
   end

   // Control FSM: IDLE waits for SDRAM init, FILL collects words until the
   // burst is full or the FIFO has been idle long enough, REQ holds the
   // request until ack, XFER hands out one word per data_req. Ack always wins
   // over a coincident data_req because data is only counted in XFER.
   always_ff @(posedge sdram_clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_fill_cnt  <= 9'd0;
         r_rd_idx    <= 9'd0;
         r_empty_cnt <= '0;
         r_ren_d     <= 1'b0;
         r_cur_addr  <= '0;
         r_req       <= 1'b0;
         r_len       <= 9'd0;
         r_total     <= 32'd0;
      end else begin
         r_ren_d <= w_ren;
         case (r_state)
            S_IDLE: begin
               if (sdram_init_done) begin
                  r_state <= S_FILL;
               end
            end
            S_FILL: begin
               if (r_ren_d) begin
                  r_fill_cnt <= r_fill_cnt + 9'd1;
               end
               if (!bus.fifo_rempty || r_ren_d) begin
                  r_empty_cnt <= '0;
               end else if (r_empty_cnt != EMPTY_MAX) begin
                  r_empty_cnt <= r_empty_cnt + EC_W'(1);
               end
               if ((r_fill_cnt == FULL_CNT) || w_flush) begin
                  r_state <= S_REQ;
                  r_req   <= 1'b1;
                  r_len   <= r_fill_cnt;
               end
            end
            S_REQ: begin
               if (bus.sdram_wr_ack) begin
                  r_req   <= 1'b0;
                  r_state <= S_XFER;
               end
            end
            S_XFER: begin
               if (bus.sdram_wr_data_req) begin
                  r_rd_idx <= r_rd_idx + 9'd1;
                  r_total  <= r_total + 32'd1;
                  if (r_rd_idx == (r_len - 9'd1)) begin
                     r_cur_addr  <= w_next_addr;
                     r_fill_cnt  <= 9'd0;
                     r_rd_idx    <= 9'd0;
                     r_empty_cnt <= '0;
                     r_state     <= sdram_init_done ? S_FILL : S_IDLE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cyp_sdram_wr_burst.sv
// ---------------------------------------------------------------------------
// tb_cyp_sdram_wr_burst
// Purpose : drives cyp_sdram_wr_burst with a queue-based FIFO model and an
//           SDRAM-controller model; expected bursts come from a word queue,
//           a linear/wrapping address model and a running word count.
// ---------------------------------------------------------------------------
module tb_cyp_sdram_wr_burst;

   localparam int BL  = 256;
   localparam int AW  = 24;
   localparam int LIM = 512;
   localparam int FTO = 100;

   logic sdram_clk = 1'b0;
   logic rst_n = 1'b0;
   logic sdram_init_done = 1'b0;

   cyp_sdram_wr_burst_if #(.ADDR_W(AW)) bus();

   cyp_sdram_wr_burst #(
      .BURST_LEN (BL),
      .ADDR_W    (AW),
      .ADDR_LIMIT(LIM),
      .FLUSH_TO  (FTO)
   ) dut (
      .sdram_clk      (sdram_clk),
      .rst_n          (rst_n),
      .sdram_init_done(sdram_init_done),
      .bus            (bus)
   );

   always #5 sdram_clk = ~sdram_clk;

   int total = 0;
   int bad = 0;
   logic [15:0] fifoQ[$];
   logic [15:0] expQ[$];
   int modelAddr = 0;
   int unsigned modelTotal = 0;
   bit renSeen = 1'b0;
   int fifoViol = 0;
   int renCount = 0;

   // FIFO model: a read seen before the edge pops a word which appears on
   // fifo_rdata just after that edge.
   initial begin
      bus.fifo_rempty = 1'b1;
      bus.fifo_rdata  = 16'd0;
      forever begin
         @(posedge sdram_clk);
         #1;
         if (renSeen && fifoQ.size() > 0) bus.fifo_rdata = fifoQ.pop_front();
         bus.fifo_rempty = (fifoQ.size() == 0);
      end
   end

   // Read-enable monitor, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge sdram_clk);
         renSeen = bus.fifo_ren;
         if (bus.fifo_ren) renCount++;
         if (bus.fifo_ren && bus.fifo_rempty) fifoViol++;
      end
   end

   task automatic pushWords(input int n, input bit seq, input int start);
      logic [15:0] w;
      for (int i = 0; i < n; i++) begin
         w = seq ? 16'(start + i) : 16'($urandom);
         fifoQ.push_back(w);
         expQ.push_back(w);
      end
   endtask

   // Controller model for one burst; entered and left on a negedge.
   task automatic serveBurst(input int expLen, input int ackDelay, input bit gapped,
                             input bit ackWithData, output int waited);
      logic [AW-1:0] a;
      logic [8:0] l;
      logic [15:0] e;
      int got = 0;
      int guard = 0;
      int dataErr = 0;
      int stableErr = 0;
      bit dr;
      waited = 0;
      while (!bus.sdram_wr_req && waited < 5000) begin
         @(negedge sdram_clk);
         waited++;
      end
      total++;
      if (!bus.sdram_wr_req) begin
         bad++;
         $display("[TB] FAIL req_timeout: req=%0b after %0d cycles, required 1", bus.sdram_wr_req, waited);
         return;
      end
      a = bus.sdram_wr_addr;
      l = bus.sdram_wr_len;
      total++;
      if (a !== AW'(modelAddr)) begin
         bad++;
         $display("[TB] FAIL burst_addr: got %0d, required %0d", a, modelAddr);
      end
      total++;
      if (l !== 9'(expLen)) begin
         bad++;
         $display("[TB] FAIL burst_len: got %0d, required %0d", l, expLen);
      end
      repeat (ackDelay) begin
         @(negedge sdram_clk);
         if (!bus.sdram_wr_req || bus.sdram_wr_addr !== a || bus.sdram_wr_len !== l) stableErr++;
      end
      total++;
      if (stableErr != 0) begin
         bad++;
         $display("[TB] FAIL req_stable: %0d unstable cycles, required 0", stableErr);
      end
      bus.sdram_wr_ack = 1'b1;
      bus.sdram_wr_data_req = ackWithData;
      @(negedge sdram_clk);
      bus.sdram_wr_ack = 1'b0;
      bus.sdram_wr_data_req = 1'b0;
      total++;
      if (bus.sdram_wr_req !== 1'b0) begin
         bad++;
         $display("[TB] FAIL req_drop: req=%0b after ack, required 0", bus.sdram_wr_req);
      end
      while (got < expLen && guard < 20000) begin
         dr = gapped ? ($urandom_range(0, 2) == 0) : 1'b1;
         guard++;
         bus.sdram_wr_data_req = dr;
         #1;
         if (dr) begin
            e = (expQ.size() > 0) ? expQ.pop_front() : 16'd0;
            if (bus.sdram_wr_data !== e) begin
               if (dataErr == 0)
                  $display("[TB] FAIL burst_data: word %0d got %h, required %h", got, bus.sdram_wr_data, e);
               dataErr++;
            end
            got++;
            modelTotal++;
         end
         @(negedge sdram_clk);
      end
      total++;
      if (dataErr != 0 || got != expLen) begin
         bad++;
         $display("[TB] FAIL burst_words: %0d bad of %0d delivered, required 0 bad of %0d", dataErr, got, expLen);
      end
      bus.sdram_wr_data_req = 1'b1;
      #1;
      total++;
      if (bus.sdram_wr_data !== 16'd0) begin
         bad++;
         $display("[TB] FAIL data_after_last: got %h, required 0000", bus.sdram_wr_data);
      end
      @(negedge sdram_clk);
      bus.sdram_wr_data_req = 1'b0;
      total++;
      if (bus.wr_words_total !== modelTotal) begin
         bad++;
         $display("[TB] FAIL words_total: got %0d, required %0d", bus.wr_words_total, modelTotal);
      end
      modelAddr = modelAddr + expLen;
      if (modelAddr >= LIM) modelAddr = 0;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      repeat (3) @(negedge sdram_clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      int renBefore;
      int busyErr = 0;
      sdram_init_done = 1'b0;
      pushWords(40, 1'b0, 0);
      applyReset();
      total++;
      if (bus.sdram_wr_req !== 1'b0 || bus.sdram_wr_addr !== '0 || bus.sdram_wr_len !== 9'd0 ||
          bus.wr_words_total !== 32'd0 || bus.wr_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_values: req=%0b addr=%0d len=%0d total=%0d busy=%0b, required all 0",
                  bus.sdram_wr_req, bus.sdram_wr_addr, bus.sdram_wr_len, bus.wr_words_total, bus.wr_busy);
      end
      renBefore = renCount;
      repeat (100) begin
         @(negedge sdram_clk);
         if (bus.wr_busy !== 1'b0) busyErr++;
      end
      total++;
      if (renCount != renBefore) begin
         bad++;
         $display("[TB] FAIL idle_no_read: %0d reads while init low, required 0", renCount - renBefore);
      end
      total++;
      if (busyErr != 0) begin
         bad++;
         $display("[TB] FAIL idle_busy: busy high %0d cycles, required 0", busyErr);
      end
      fifoQ.delete();
      expQ.delete();
      @(negedge sdram_clk);
   endtask

   task automatic test_two_bursts();
      int w;
      pushWords(512, 1'b1, 0);
      @(negedge sdram_clk);
      sdram_init_done = 1'b1;
      serveBurst(BL, 3, 1'b0, 1'b0, w);
      serveBurst(BL, 3, 1'b0, 1'b0, w);
   endtask

   task automatic test_partial_flush();
      int w;
      pushWords(10, 1'b0, 0);
      serveBurst(10, $urandom_range(0, 4), 1'b0, 1'b1, w);
      total++;
      if (w < FTO + 10 || w > FTO + 30) begin
         bad++;
         $display("[TB] FAIL flush_timing: req after %0d cycles, required %0d..%0d", w, FTO + 10, FTO + 30);
      end
   endtask

   task automatic test_gapped();
      int w;
      pushWords(BL, 1'b0, 0);
      serveBurst(BL, $urandom_range(0, 5), 1'b1, 1'b0, w);
   endtask

   task automatic test_mid_xfer_reset();
      int waited = 0;
      pushWords(BL, 1'b0, 0);
      while (!bus.sdram_wr_req && waited < 5000) begin
         @(negedge sdram_clk);
         waited++;
      end
      bus.sdram_wr_ack = 1'b1;
      @(negedge sdram_clk);
      bus.sdram_wr_ack = 1'b0;
      repeat (50) begin
         bus.sdram_wr_data_req = 1'b1;
         @(negedge sdram_clk);
      end
      bus.sdram_wr_data_req = 1'b0;
      rst_n = 1'b0;
      @(posedge sdram_clk);
      #1;
      total++;
      if (bus.sdram_wr_req !== 1'b0 || bus.fifo_ren !== 1'b0 || bus.sdram_wr_addr !== '0 ||
          bus.wr_busy !== 1'b0 || bus.wr_words_total !== 32'd0) begin
         bad++;
         $display("[TB] FAIL mid_xfer_reset: req=%0b ren=%0b addr=%0d busy=%0b total=%0d, required all 0",
                  bus.sdram_wr_req, bus.fifo_ren, bus.sdram_wr_addr, bus.wr_busy, bus.wr_words_total);
      end
      fifoQ.delete();
      expQ.delete();
      modelAddr = 0;
      modelTotal = 0;
      @(negedge sdram_clk);
      rst_n = 1'b1;
   endtask

   task automatic test_addr_wrap();
      int w;
      int renBefore;
      int busyErr = 0;
      pushWords(3 * BL, 1'b0, 0);
      serveBurst(BL, 0, 1'b0, 1'b1, w);
      serveBurst(BL, $urandom_range(1, 6), 1'b1, 1'b0, w);
      sdram_init_done = 1'b0;
      serveBurst(BL, 2, 1'b0, 1'b1, w);
      pushWords(20, 1'b0, 0);
      renBefore = renCount;
      repeat (50) begin
         @(negedge sdram_clk);
         if (bus.wr_busy !== 1'b0) busyErr++;
      end
      total++;
      if (busyErr != 0 || renCount != renBefore) begin
         bad++;
         $display("[TB] FAIL back_to_idle: busy cycles=%0d reads=%0d, required 0 and 0",
                  busyErr, renCount - renBefore);
      end
   endtask

   initial begin
      bus.sdram_wr_ack = 1'b0;
      bus.sdram_wr_data_req = 1'b0;
      @(negedge sdram_clk);
      test_reset();
      test_two_bursts();
      test_partial_flush();
      test_gapped();
      test_mid_xfer_reset();
      test_addr_wrap();
      total++;
      if (fifoViol != 0) begin
         bad++;
         $display("[TB] FAIL fifo_rule: ren while empty %0d times, required 0", fifoViol);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation still running, required finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
